dcache_req_responder: RTL and testbench



---
 rtl/drac_pkg.sv | 97 +++++++++
 rtl/dcache_req_responder_amo_alu.sv | 41 ++++
 rtl/dcache_req_responder.sv | 179 +++++++++++++++++
 tb/tb_dcache_req_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared types and helpers for the memory-unit to dcache request path.
package drac_pkg;

  typedef logic [4:0] reg_t;

  typedef enum logic [1:0] {
    MEM_NOP,
    MEM_LOAD,
    MEM_STORE,
    MEM_AMO
  } mem_op_t;

  typedef enum logic [3:0] {
    INSTR_OTHER,
    AMOSWAP,
    AMOADD,
    AMOAND,
    AMOOR,
    AMOXOR,
    AMOMIN,
    AMOMAX,
    AMOMINU,
    AMOMAXU
  } instr_type_t;

  typedef enum logic [3:0] {
    AMO_SWAP,
    AMO_ADD,
    AMO_AND,
    AMO_OR,
    AMO_XOR,
    AMO_MIN,
    AMO_MAX,
    AMO_MINU,
    AMO_MAXU
  } amo_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DRAIN
  } dcache_resp_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  function automatic amo_op_t amo_decode(input instr_type_t t);
    case (t)
      AMOADD:  return AMO_ADD;
      AMOAND:  return AMO_AND;
      AMOOR:   return AMO_OR;
      AMOXOR:  return AMO_XOR;
      AMOMIN:  return AMO_MIN;
      AMOMAX:  return AMO_MAX;
      AMOMINU: return AMO_MINU;
      AMOMAXU: return AMO_MAXU;
      default: return AMO_SWAP;
    endcase
  endfunction

  // Misaligned offsets are forced down to the natural boundary of the access.
  function automatic logic [2:0] align_offset(input logic [2:0] off, input logic [1:0] size);
    case (size)
      SIZE_B:  return off;
      SIZE_H:  return {off[2:1], 1'b0};
      SIZE_W:  return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // funct3[2] selects zero extension; shared with the LSQ forwarding path.
  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] off,
                                              input logic [2:0] funct3);
    logic [63:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3[1:0])
      SIZE_B:  return {{56{sh[7] & ~funct3[2]}}, sh[7:0]};
      SIZE_H:  return {{48{sh[15] & ~funct3[2]}}, sh[15:0]};
      SIZE_W:  return {{32{sh[31] & ~funct3[2]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/dcache_req_responder_amo_alu.sv
// Combinational AMO datapath: new memory value from the old value and the operand.
module amo_alu
  import drac_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] operand,
  input  amo_op_t           op,
  input  logic              is_word,
  output logic [DATA_W-1:0] new_val
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [DATA_W-1:0] a_u;
  logic        [DATA_W-1:0] b_u;
  logic        [DATA_W-1:0] res;

  always_comb begin
    // Word ops compare on the low half, extended the way each comparison needs.
    a_u = is_word ? {{(DATA_W-32){1'b0}}, old_val[31:0]} : old_val;
    b_u = is_word ? {{(DATA_W-32){1'b0}}, operand[31:0]} : operand;
    a_s = is_word ? {{(DATA_W-32){old_val[31]}}, old_val[31:0]} : old_val;
    b_s = is_word ? {{(DATA_W-32){operand[31]}}, operand[31:0]} : operand;
    case (op)
      AMO_SWAP: res = b_u;
      AMO_ADD:  res = a_u + b_u;
      AMO_AND:  res = a_u & b_u;
      AMO_OR:   res = a_u | b_u;
      AMO_XOR:  res = a_u ^ b_u;
      AMO_MIN:  res = (a_s < b_s) ? a_u : b_u;
      AMO_MAX:  res = (a_s > b_s) ? a_u : b_u;
      AMO_MINU: res = (a_u < b_u) ? a_u : b_u;
      AMO_MAXU: res = (a_u > b_u) ? a_u : b_u;
      default:  res = b_u;
    endcase
    new_val = is_word ? {{(DATA_W-32){1'b0}}, res[31:0]} : res;
  end

endmodule

// File: rtl/dcache_req_responder.sv
// Dcache-side endpoint: runs one load/store/AMO at a time onto a valid/ready memory port.
module dcache_req_responder
  import drac_pkg::*;
#(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_rs1_i,
  input  logic [DATA_W-1:0] data_rs2_i,
  input  instr_type_t       instr_type_i,
  input  mem_op_t           mem_op_i,
  input  logic [2:0]        funct3_i,
  input  reg_t              rd_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              kill_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output reg_t              rd_o,
  output logic              lock_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [7:0]        mem_req_be_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i
);

  dcache_resp_state_t state, state_next;

  mem_op_t           op_q;
  amo_op_t           amo_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] data_q;
  reg_t              rd_q;
  reg_t              rd_out_q;
  logic              ready_q;

  logic              accept;
  logic              rd_resp;
  logic              wr_hs;
  logic [2:0]        off;
  logic [2:0]        req_off;
  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] amo_new;
  logic              unused_ok;

  assign unused_ok = ^{imm_i, data_rs1_i[DATA_W-1:ADDR_W]};

  assign req_off = align_offset(data_rs1_i[2:0], funct3_i[1:0]);
  assign off     = addr_q[2:0];
  assign ext_val = load_extend(mem_resp_data_i, off, funct3_q);

  amo_alu #(.DATA_W(DATA_W)) u_amo_alu (
    .old_val (ext_val),
    .operand (wdata_q),
    .op      (amo_q),
    .is_word (funct3_q[1:0] == SIZE_W),
    .new_val (amo_new)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    rd_resp         = 1'b0;
    wr_hs           = 1'b0;
    lock_o          = (state != IDLE);
    mem_req_valid_o = (state == RD_REQ) || (state == WR_REQ);
    mem_req_we_o    = (state == WR_REQ);
    case (state)
      IDLE: begin
        if (valid_i && !kill_i) begin
          accept     = 1'b1;
          state_next = (mem_op_i == MEM_STORE) ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        // A handshake in the kill cycle wins; the read is then drained normally.
        if (mem_req_ready_i) state_next = RD_WAIT;
        else if (kill_i)     state_next = IDLE;
      end
      RD_WAIT: begin
        if (mem_resp_valid_i) begin
          rd_resp    = 1'b1;
          state_next = (op_q == MEM_AMO) ? WR_REQ : IDLE;
        end else if (kill_i) begin
          state_next = DRAIN;
        end
      end
      WR_REQ: begin
        if (mem_req_ready_i) begin
          wr_hs      = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (mem_resp_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_addr_o  = '0;
    mem_req_be_o    = '0;
    mem_req_wdata_o = '0;
    if (mem_req_valid_o) begin
      mem_req_addr_o = {addr_q[ADDR_W-1:3], 3'b000};
      mem_req_be_o   = byte_mask(funct3_q[1:0]) << off;
    end
    if (mem_req_we_o) mem_req_wdata_o = wdata_q << {off, 3'b000};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= MEM_NOP;
      amo_q    <= AMO_SWAP;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (accept) begin
        op_q     <= mem_op_i;
        amo_q    <= amo_decode(instr_type_i);
        funct3_q <= funct3_i;
        addr_q   <= {data_rs1_i[ADDR_W-1:3], req_off};
        wdata_q  <= data_rs2_i;
        rd_q     <= rd_i;
      end
      if (rd_resp) begin
        // An AMO keeps the old value for its result and reuses wdata_q for the write-back.
        if (op_q == MEM_AMO) begin
          old_q   <= ext_val;
          wdata_q <= amo_new;
        end else begin
          ready_q  <= 1'b1;
          data_q   <= ext_val;
          rd_out_q <= rd_q;
        end
      end
      if (wr_hs && (op_q == MEM_AMO)) begin
        ready_q  <= 1'b1;
        data_q   <= old_q;
        rd_out_q <= rd_q;
      end
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;
  assign rd_o    = rd_out_q;

`ifdef ASSERTIONS
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept)
      assert (req_off == data_rs1_i[2:0])
        else $error("misaligned dcache access at %h", data_rs1_i[ADDR_W-1:0]);
  end
`endif

endmodule

// File: tb/tb_dcache_req_responder.sv
// Bench for dcache_req_responder: vector table, multi-cycle corner sequences, random ops vs model.
module tb_dcache_req_responder;
  import drac_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [63:0] data_rs1_i = '0;
  logic [63:0] data_rs2_i = '0;
  instr_type_t instr_type_i = INSTR_OTHER;
  mem_op_t     mem_op_i = MEM_NOP;
  logic [2:0]  funct3_i = '0;
  reg_t        rd_i = '0;
  logic [63:0] imm_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o;
  logic [63:0] data_o;
  reg_t        rd_o;
  logic        lock_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_req_we_o;
  logic [39:0] mem_req_addr_o;
  logic [7:0]  mem_req_be_o;
  logic [63:0] mem_req_wdata_o;
  logic        mem_resp_valid_i = 1'b0;
  logic [63:0] mem_resp_data_i = '0;

  always #5 clk_i = ~clk_i;

  dcache_req_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_rs1_i(data_rs1_i),
    .data_rs2_i(data_rs2_i), .instr_type_i(instr_type_i), .mem_op_i(mem_op_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .imm_i(imm_i), .kill_i(kill_i),
    .ready_o(ready_o), .data_o(data_o), .rd_o(rd_o), .lock_o(lock_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_be_o(mem_req_be_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] mem [16];
  logic [63:0] last_data = '0;
  reg_t        last_rd = '0;

  typedef struct {
    mem_op_t     op;
    instr_type_t it;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [2:0]  f3;
    logic [63:0] mword;
    logic [63:0] exp_data;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_data"}, data_o, 64'd0);
    chk({tag, "_rd"}, 64'(rd_o), 64'd0);
    chk({tag, "_lock"}, 64'(lock_o), 64'd0);
    chk({tag, "_req_valid"}, 64'(mem_req_valid_o), 64'd0);
    chk({tag, "_we"}, 64'(mem_req_we_o), 64'd0);
    chk({tag, "_addr"}, 64'(mem_req_addr_o), 64'd0);
    chk({tag, "_be"}, 64'(mem_req_be_o), 64'd0);
    chk({tag, "_wdata"}, mem_req_wdata_o, 64'd0);
  endtask

  // Reference rules, written from the access-size and extension definitions.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off, input logic [2:0] f3);
    int n;
    logic [63:0] v, mask;
    n = 1 << f3[1:0];
    v = word >> (8 * off);
    if (n < 8) begin
      mask = (64'h1 << (8 * n)) - 64'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_merge(input logic [63:0] word, input logic [63:0] val,
                                            input int off, input int n);
    logic [63:0] w;
    w = word;
    for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = val[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] ref_amo(input instr_type_t it, input logic [63:0] old,
                                          input logic [63:0] b, input bit w);
    longint sa, sb;
    longint unsigned ua, ub, r;
    if (w) begin
      sa = longint'(int'(old[31:0])); sb = longint'(int'(b[31:0]));
      ua = {32'h0, old[31:0]};        ub = {32'h0, b[31:0]};
    end else begin
      sa = old; sb = b; ua = old; ub = b;
    end
    case (it)
      AMOADD:  r = ua + ub;
      AMOAND:  r = ua & ub;
      AMOOR:   r = ua | ub;
      AMOXOR:  r = ua ^ ub;
      AMOMIN:  r = (sa < sb) ? ua : ub;
      AMOMAX:  r = (sa > sb) ? ua : ub;
      AMOMINU: r = (ua < ub) ? ua : ub;
      AMOMAXU: r = (ua > ub) ? ua : ub;
      default: r = ub;
    endcase
    return r;
  endfunction

  task automatic issue(input mem_op_t op, input instr_type_t it, input logic [63:0] a,
                       input logic [63:0] rs2, input logic [2:0] f3, input reg_t rd);
    valid_i = 1'b1; mem_op_i = op; instr_type_i = it; data_rs1_i = a;
    data_rs2_i = rs2; funct3_i = f3; rd_i = rd;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic run_op(input mem_op_t op, input instr_type_t it, input logic [63:0] a,
                        input logic [63:0] rs2, input logic [2:0] f3, input reg_t rd,
                        input int rdly, input int pdly, input logic [63:0] exp_data,
                        input logic [63:0] exp_word);
    int idx, off, n;
    logic [7:0]  be_exp;
    logic [63:0] aexp;
    idx = int'(a[6:3]); off = int'(a[2:0]); n = 1 << f3[1:0];
    be_exp = 8'(((1 << n) - 1) << off);
    aexp = {24'h0, a[39:3], 3'b000};
    issue(op, it, a, rs2, f3, rd);
    chk("lock_busy", 64'(lock_o), 64'd1);
    if (op != MEM_STORE) begin
      for (int i = 0; i < rdly; i++) begin
        chk("rd_req_hold", 64'(mem_req_valid_o), 64'd1);
        @(negedge clk_i);
      end
      chk("rd_req_valid", 64'(mem_req_valid_o), 64'd1);
      chk("rd_req_we", 64'(mem_req_we_o), 64'd0);
      chk("rd_req_addr", 64'(mem_req_addr_o), aexp);
      mem_req_ready_i = 1'b1;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      for (int i = 0; i < pdly; i++) begin
        chk("rd_wait_lock", 64'(lock_o), 64'd1);
        chk("rd_wait_noreq", 64'(mem_req_valid_o), 64'd0);
        @(negedge clk_i);
      end
      mem_resp_valid_i = 1'b1; mem_resp_data_i = mem[idx];
      @(negedge clk_i);
      mem_resp_valid_i = 1'b0;
      if (op != MEM_AMO) begin
        chk("ld_ready", 64'(ready_o), 64'd1);
        chk("ld_data", data_o, exp_data);
        chk("ld_rd", 64'(rd_o), 64'(rd));
        chk("ld_lock_free", 64'(lock_o), 64'd0);
        last_data = exp_data; last_rd = rd;
        @(negedge clk_i);
        chk("ld_pulse_end", 64'(ready_o), 64'd0);
        chk("ld_data_hold", data_o, exp_data);
        return;
      end
    end
    for (int i = 0; i < rdly; i++) begin
      chk("wr_req_hold", 64'(mem_req_valid_o), 64'd1);
      @(negedge clk_i);
    end
    chk("wr_req_valid", 64'(mem_req_valid_o), 64'd1);
    chk("wr_req_we", 64'(mem_req_we_o), 64'd1);
    chk("wr_req_addr", 64'(mem_req_addr_o), aexp);
    chk("wr_req_be", 64'(mem_req_be_o), 64'(be_exp));
    for (int b = 0; b < 8; b++)
      if (mem_req_be_o[b]) mem[idx][8*b +: 8] = mem_req_wdata_o[8*b +: 8];
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    chk("mem_word", mem[idx], exp_word);
    chk("wr_lock_free", 64'(lock_o), 64'd0);
    if (op == MEM_AMO) begin
      chk("amo_ready", 64'(ready_o), 64'd1);
      chk("amo_data", data_o, exp_data);
      chk("amo_rd", 64'(rd_o), 64'(rd));
      last_data = exp_data; last_rd = rd;
    end else begin
      chk("st_no_ready", 64'(ready_o), 64'd0);
      chk("st_data_hold", data_o, last_data);
      chk("st_rd_hold", 64'(rd_o), 64'(last_rd));
    end
    @(negedge clk_i);
    chk("wr_pulse_end", 64'(ready_o), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{MEM_LOAD,  INSTR_OTHER, 64'h1000_0008, 64'h0, 3'd3, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    vt[1]  = '{MEM_LOAD,  INSTR_OTHER, 64'h1000_0003, 64'h0, 3'd0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_8000_0000};
    vt[2]  = '{MEM_LOAD,  INSTR_OTHER, 64'h1000_0003, 64'h0, 3'd4, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 64'h0000_0000_8000_0000};
    vt[3]  = '{MEM_LOAD,  INSTR_OTHER, 64'h1000_0016, 64'h0, 3'd1, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 64'h8001_0000_0000_0000};
    vt[4]  = '{MEM_LOAD,  INSTR_OTHER, 64'h1000_0024, 64'h0, 3'd6, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 64'h89AB_CDEF_0000_0000};
    vt[5]  = '{MEM_LOAD,  INSTR_OTHER, 64'h1000_0024, 64'h0, 3'd2, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF, 64'h89AB_CDEF_0000_0000};
    vt[6]  = '{MEM_STORE, INSTR_OTHER, 64'h1000_0006, 64'hABCD, 3'd1, 64'h0, 64'h0, 64'hABCD_0000_0000_0000};
    vt[7]  = '{MEM_STORE, INSTR_OTHER, 64'h1000_0031, 64'h1234_5678, 3'd0, 64'h1111_1111_1111_1111, 64'h0, 64'h1111_1111_1111_7811};
    vt[8]  = '{MEM_AMO,   AMOADD,  64'h1000_0040, 64'h1, 3'd2, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_8000_0000};
    vt[9]  = '{MEM_AMO,   AMOSWAP, 64'h1000_0048, 64'hCAFE, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_CAFE};
    vt[10] = '{MEM_AMO,   AMOMINU, 64'h1000_0054, 64'h3, 3'd2, 64'hFFFF_FFFE_0000_0005, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0003_0000_0005};
    vt[11] = '{MEM_AMO,   AMOMAX,  64'h1000_0058, 64'h5, 3'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0005};
    vt[12] = '{MEM_AMO,   AMOXOR,  64'h1000_0060, 64'hFFFF_FFFF_FFFF_00FF, 3'd2, 64'hAAAA_AAAA_0F0F_0F0F, 64'h0000_0000_0F0F_0F0F, 64'hAAAA_AAAA_F0F0_0FF0};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk_reset("rst");

    for (int i = 0; i < 13; i++) begin
      mem[int'(vt[i].addr[6:3])] = vt[i].mword;
      run_op(vt[i].op, vt[i].it, vt[i].addr, vt[i].rs2, vt[i].f3, reg_t'(i + 1),
             (i == 0) ? 0 : i % 3, (i == 0) ? 2 : i % 4, vt[i].exp_data, vt[i].exp_word);
    end

    // Kill while waiting for read data: response is drained, no result.
    mem[2] = 64'h5555_AAAA_1234_0000;
    issue(MEM_LOAD, INSTR_OTHER, 64'h1000_0010, 64'h0, 3'd3, 5'd20);
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_lock", 64'(lock_o), 64'd1);
      chk("drain_no_ready", 64'(ready_o), 64'd0);
      @(negedge clk_i);
    end
    mem_resp_valid_i = 1'b1; mem_resp_data_i = mem[2];
    chk("drain_lock_resp_cycle", 64'(lock_o), 64'd1);
    @(negedge clk_i);
    mem_resp_valid_i = 1'b0;
    chk("drain_lock_free", 64'(lock_o), 64'd0);
    chk("drain_no_ready_after", 64'(ready_o), 64'd0);
    chk("drain_data_hold", data_o, last_data);
    run_op(vt[0].op, vt[0].it, vt[0].addr, vt[0].rs2, vt[0].f3, 5'd21, 0, 1,
           vt[0].exp_data, vt[0].exp_word);

    // Kill in RD_REQ without a handshake abandons the request.
    issue(MEM_LOAD, INSTR_OTHER, 64'h1000_0010, 64'h0, 3'd3, 5'd22);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    chk("kill_req_lock", 64'(lock_o), 64'd0);
    chk("kill_req_novalid", 64'(mem_req_valid_o), 64'd0);
    @(negedge clk_i);
    chk("kill_req_no_ready", 64'(ready_o), 64'd0);

    // Kill together with the handshake: the handshake wins and the load completes.
    issue(MEM_LOAD, INSTR_OTHER, 64'h1000_0010, 64'h0, 3'd3, 5'd23);
    kill_i = 1'b1; mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0; mem_req_ready_i = 1'b0;
    chk("kill_hs_lock", 64'(lock_o), 64'd1);
    mem_resp_valid_i = 1'b1; mem_resp_data_i = mem[2];
    @(negedge clk_i);
    mem_resp_valid_i = 1'b0;
    chk("kill_hs_ready", 64'(ready_o), 64'd1);
    chk("kill_hs_data", data_o, 64'h5555_AAAA_1234_0000);
    chk("kill_hs_rd", 64'(rd_o), 64'd23);
    last_data = 64'h5555_AAAA_1234_0000; last_rd = 5'd23;
    @(negedge clk_i);

    // A request arriving with kill is not accepted.
    kill_i = 1'b1;
    issue(MEM_LOAD, INSTR_OTHER, 64'h1000_0010, 64'h0, 3'd3, 5'd24);
    kill_i = 1'b0;
    chk("kill_accept_lock", 64'(lock_o), 64'd0);

    // Kill during WR_REQ is ignored; the store still completes.
    mem[5] = 64'h0;
    issue(MEM_STORE, INSTR_OTHER, 64'h1000_0028, 64'h0000_0000_CAFE_F00D, 3'd2, 5'd25);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    chk("kill_wr_valid", 64'(mem_req_valid_o), 64'd1);
    chk("kill_wr_we", 64'(mem_req_we_o), 64'd1);
    chk("kill_wr_wdata", mem_req_wdata_o & 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_CAFE_F00D);
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    chk("kill_wr_done", 64'(lock_o), 64'd0);

    // Randomized operations against the reference rules.
    for (int k = 0; k < 40; k++) begin
      int sel, idx, n, off;
      logic [2:0] f3;
      instr_type_t it;
      mem_op_t op;
      logic [63:0] a, rs2, old_ext, ed, ew;
      sel = $urandom_range(0, 2);
      idx = $urandom_range(0, 15);
      it = INSTR_OTHER;
      if (sel == 0) begin op = MEM_LOAD; f3 = 3'($urandom_range(0, 6)); end
      else if (sel == 1) begin op = MEM_STORE; f3 = 3'($urandom_range(0, 3)); end
      else begin op = MEM_AMO; f3 = 3'($urandom_range(2, 3)); it = instr_type_t'($urandom_range(1, 9)); end
      n = 1 << f3[1:0];
      off = $urandom_range(0, 8 / n - 1) * n;
      a = 64'h1000_0000 + 64'(idx * 8 + off);
      mem[idx] = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      old_ext = ref_load(mem[idx], off, f3);
      ed = old_ext; ew = mem[idx];
      if (op == MEM_STORE) ew = ref_merge(mem[idx], rs2, off, n);
      if (op == MEM_AMO) ew = ref_merge(mem[idx], ref_amo(it, old_ext, rs2, f3[1:0] == 2'd2), off, n);
      run_op(op, it, a, rs2, f3, reg_t'($urandom_range(0, 31)), $urandom_range(0, 3),
             $urandom_range(0, 3), ed, ew);
    end

    // Memory stalls the read, then reset is applied mid-operation.
    issue(MEM_LOAD, INSTR_OTHER, 64'h1000_0008, 64'h0, 3'd3, 5'd30);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", 64'(mem_req_valid_o), 64'd1);
      @(negedge clk_i);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_reset("midrst");
    last_data = '0; last_rd = '0;
    mem[1] = vt[0].mword;
    run_op(vt[0].op, vt[0].it, vt[0].addr, vt[0].rs2, vt[0].f3, 5'd31, 1, 0,
           vt[0].exp_data, vt[0].exp_word);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
